// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM PIN entry stage.
// Holds the FSM state encoding, BCD limit and default sizing.
package atm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_CHECK,
      ST_GRANTED,
      ST_LOCKED
   } state_e;

   localparam int BCD_MAX        = 9;
   localparam int DEF_PIN_DIGITS = 4;
   localparam int DEF_DIGIT_W    = 4;
   localparam int DEF_MAX_TRIES  = 3;
   localparam int DEF_PIN_W      = DEF_PIN_DIGITS * DEF_DIGIT_W;

   // Attempt counter never wraps below zero.
   function automatic logic [2:0] sat_dec3(input logic [2:0] v);
      return (v == 3'd0) ? 3'd0 : v - 3'd1;
   endfunction

endpackage

// File: rtl/atm_pin_entry_if.sv
// Keypad/card/timer signal bundle for the PIN entry stage.
// master drives the keypad side; slave is the PIN entry block.
interface atm_pin_entry_if
   import atm_pkg::*;
#(
   parameter int PIN_W   = DEF_PIN_W,
   parameter int DIGIT_W = DEF_DIGIT_W
) ();

   logic               card_in;
   logic               digit_valid;
   logic [DIGIT_W-1:0] digit;
   logic               enter;
   logic               cancel;
   logic [PIN_W-1:0]   stored_pin;
   logic               time_out;
   logic               timer_restart;
   logic               pin_ok;
   logic               pin_fail;
   logic               card_locked;
   logic               eject;
   logic [2:0]         tries_left;
   logic [3:0]         digits_cnt;

   modport master (
      output card_in, digit_valid, digit, enter, cancel, stored_pin, time_out,
      input  timer_restart, pin_ok, pin_fail, card_locked, eject, tries_left, digits_cnt
   );

   modport slave (
      input  card_in, digit_valid, digit, enter, cancel, stored_pin, time_out,
      output timer_restart, pin_ok, pin_fail, card_locked, eject, tries_left, digits_cnt
   );

endinterface

// File: rtl/pin_shift_reg.sv
// Keypad digit buffer: shifts digits in from the LSB end, counts them,
// saturates at PIN_DIGITS and clears on request (clear wins over shift).
module pin_shift_reg #(
   parameter int PIN_DIGITS = 4,
   parameter int DIGIT_W    = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clear,
   input  logic                           shift_en,
   input  logic [DIGIT_W-1:0]             digit_in,
   output logic [PIN_DIGITS*DIGIT_W-1:0]  entry,
   output logic [3:0]                     count,
   output logic                           full
);

   localparam int PIN_W = PIN_DIGITS * DIGIT_W;

   logic [PIN_W-1:0] entry_q, entry_d, shifted;
   logic [3:0]       count_q, count_d;

   // First digit entered ends up in the MSBs once the buffer is full.
   if (PIN_DIGITS > 1) begin : g_multi
      assign shifted = {entry_q[PIN_W-DIGIT_W-1:0], digit_in};
   end else begin : g_single
      assign shifted = digit_in;
   end

   assign full = (count_q == 4'(PIN_DIGITS));

   always_comb begin
      entry_d = entry_q;
      count_d = count_q;
      if (clear) begin
         entry_d = '0;
         count_d = 4'd0;
      end else if (shift_en && !full) begin
         entry_d = shifted;
         count_d = count_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry_q <= '0;
         count_q <= 4'd0;
      end else begin
         entry_q <= entry_d;
         count_q <= count_d;
      end
   end

   assign entry = entry_q;
   assign count = count_q;

endmodule

// File: rtl/atm_pin_entry.sv
// ATM authentication stage: collects keypad digits, checks them against the
// card PIN latched at insertion, tracks failed attempts and retains the card.
module atm_pin_entry
   import atm_pkg::*;
#(
   parameter int PIN_DIGITS = DEF_PIN_DIGITS,
   parameter int MAX_TRIES  = DEF_MAX_TRIES,
   parameter int DIGIT_W    = DEF_DIGIT_W
) (
   input logic            clk,
   input logic            rst,
   atm_pin_entry_if.slave bus
);

   localparam int PIN_W = PIN_DIGITS * DIGIT_W;

   state_e           state_q, state_d;
   logic             card_prev_q, card_prev_d;
   logic [PIN_W-1:0] pin_q, pin_d;
   logic [2:0]       tries_q, tries_d, tries_dec;
   logic             timer_restart_q, timer_restart_d;
   logic             pin_ok_q, pin_ok_d;
   logic             pin_fail_q, pin_fail_d;
   logic             eject_q, eject_d;
   logic             card_locked_q, card_locked_d;

   logic             sr_clear, sr_shift, sr_full;
   logic [PIN_W-1:0] entry;
   logic [3:0]       count;
   logic             card_rise, abort, match, digit_ok;

   pin_shift_reg #(
      .PIN_DIGITS (PIN_DIGITS),
      .DIGIT_W    (DIGIT_W)
   ) u_shift (
      .clk      (clk),
      .rst      (rst),
      .clear    (sr_clear),
      .shift_en (sr_shift),
      .digit_in (bus.digit),
      .entry    (entry),
      .count    (count),
      .full     (sr_full)
   );

   assign card_prev_d = bus.card_in;
   assign card_rise   = bus.card_in && !card_prev_q;
   assign abort       = bus.cancel || bus.time_out;
   assign digit_ok    = (bus.digit <= DIGIT_W'(BCD_MAX));
   assign match       = (count == 4'(PIN_DIGITS)) && (entry == pin_q);
   assign tries_dec   = sat_dec3(tries_q);

   // The verdict is decided when enter is sampled and registered, so the
   // result pulses are visible during the one-cycle CHECK state.
   always_comb begin
      state_d         = state_q;
      pin_d           = pin_q;
      tries_d         = tries_q;
      timer_restart_d = 1'b0;
      pin_ok_d        = 1'b0;
      pin_fail_d      = 1'b0;
      eject_d         = 1'b0;
      card_locked_d   = card_locked_q;
      sr_clear        = 1'b0;
      sr_shift        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (card_rise) begin
               pin_d           = bus.stored_pin;
               tries_d         = 3'(MAX_TRIES);
               sr_clear        = 1'b1;
               timer_restart_d = 1'b1;
               state_d         = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (!bus.card_in) begin
               sr_clear = 1'b1;
               state_d  = ST_IDLE;
            end else if (abort) begin
               eject_d  = 1'b1;
               sr_clear = 1'b1;
               state_d  = ST_IDLE;
            end else if (bus.enter) begin
               state_d = ST_CHECK;
               if (match) begin
                  pin_ok_d = 1'b1;
               end else begin
                  tries_d = tries_dec;
                  if (tries_dec == 3'd0) begin
                     card_locked_d = 1'b1;
                  end else begin
                     pin_fail_d      = 1'b1;
                     sr_clear        = 1'b1;
                     timer_restart_d = 1'b1;
                  end
               end
            end else if (bus.digit_valid && digit_ok && !sr_full) begin
               sr_shift        = 1'b1;
               timer_restart_d = 1'b1;
            end
         end
         ST_CHECK: begin
            // A lock already decided keeps the card even if it is pulled now.
            if (card_locked_q) begin
               state_d = ST_LOCKED;
            end else if (!bus.card_in) begin
               sr_clear = 1'b1;
               state_d  = ST_IDLE;
            end else if (abort) begin
               eject_d  = 1'b1;
               sr_clear = 1'b1;
               state_d  = ST_IDLE;
            end else if (pin_ok_q) begin
               state_d = ST_GRANTED;
            end else begin
               state_d = ST_COLLECT;
            end
         end
         ST_GRANTED: begin
            if (!bus.card_in) begin
               sr_clear = 1'b1;
               state_d  = ST_IDLE;
            end else if (abort) begin
               eject_d  = 1'b1;
               sr_clear = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            state_d = ST_LOCKED;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // card_prev resets high so a card left in the reader across a reset
   // must be removed and reinserted before a new session starts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         card_prev_q     <= 1'b1;
         pin_q           <= '0;
         tries_q         <= 3'(MAX_TRIES);
         timer_restart_q <= 1'b0;
         pin_ok_q        <= 1'b0;
         pin_fail_q      <= 1'b0;
         eject_q         <= 1'b0;
         card_locked_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         card_prev_q     <= card_prev_d;
         pin_q           <= pin_d;
         tries_q         <= tries_d;
         timer_restart_q <= timer_restart_d;
         pin_ok_q        <= pin_ok_d;
         pin_fail_q      <= pin_fail_d;
         eject_q         <= eject_d;
         card_locked_q   <= card_locked_d;
      end
   end

   assign bus.timer_restart = timer_restart_q;
   assign bus.pin_ok        = pin_ok_q;
   assign bus.pin_fail      = pin_fail_q;
   assign bus.eject         = eject_q;
   assign bus.card_locked   = card_locked_q;
   assign bus.tries_left    = tries_q;
   assign bus.digits_cnt    = count;

endmodule

// File: doc/atm_pin_entry.md
Name: atm_pin_entry

Overview:
- Authentication stage of the ATM: collects keypad digits, compares them with the card's stored PIN, counts failed attempts and locks the card on exhaustion.
- Directly upstream of the inactivity timer. It drives that timer's restart input and consumes its time_out pulse to abort idle sessions.
- Downstream consumers (transaction FSM, card reader) see single-cycle grant/fail pulses and level status outputs.

Parameters:
- PIN_DIGITS, 4, number of digits in a PIN (1..8).
- MAX_TRIES, 3, failed attempts allowed before lock (1..7).
- DIGIT_W, 4, keypad digit width (BCD).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- card_in  in  1  level: card present in reader.
- digit_valid  in  1  one-cycle strobe: digit is valid this cycle.
- digit  in  DIGIT_W  keypad value; only 0..9 accepted.
- enter  in  1  one-cycle strobe: submit entry.
- cancel  in  1  one-cycle strobe: abort session.
- stored_pin  in  PIN_DIGITS*DIGIT_W  reference PIN; digit 0 in MSBs; sampled on card insertion.
- time_out  in  1  one-cycle pulse from inactivity timer.
- timer_restart  out  1  one-cycle pulse to reset inactivity timer.
- pin_ok  out  1  one-cycle pulse: PIN matched.
- pin_fail  out  1  one-cycle pulse: wrong/short PIN, tries remain.
- card_locked  out  1  level: card retained, session dead.
- eject  out  1  one-cycle pulse: return card.
- tries_left  out  3  remaining attempts.
- digits_cnt  out  4  digits entered so far (display masking).

Behaviour:
- Reset (async): state IDLE. All pulses 0, card_locked 0, tries_left=MAX_TRIES, digits_cnt 0, entry register 0.
- States: IDLE, COLLECT, CHECK, GRANTED, LOCKED.
- Event priority, highest first: card_in low, cancel, time_out, enter, digit_valid.
- IDLE:
  - On card_in rising (registered edge detect): latch stored_pin, tries_left=MAX_TRIES, digits_cnt=0, pulse timer_restart, go COLLECT.
- COLLECT:
  - digit_valid with digit<=9 and digits_cnt<PIN_DIGITS: shift digit into entry, digits_cnt+1, pulse timer_restart.
  - digit>9, or buffer already full: ignored; no timer_restart.
  - enter: go CHECK next cycle.
  - cancel or time_out: pulse eject, go IDLE.
- CHECK (exactly 1 cycle):
  - Match requires digits_cnt==PIN_DIGITS and entry==latched PIN.
  - Match: pulse pin_ok, go GRANTED.
  - Mismatch: tries_left-1. If result is 0: card_locked=1, go LOCKED, no pin_fail. Else: pulse pin_fail, clear entry and digits_cnt, pulse timer_restart, go COLLECT.
  - Latency: pin_ok/pin_fail/card_locked asserted in the cycle after the cycle in which enter is sampled.
- GRANTED:
  - Holds; ignores digits and enter.
  - cancel or time_out: pulse eject, go IDLE.
  - The transaction stage owns the timer restart policy here; this block does not pulse timer_restart.
- LOCKED:
  - card_locked held; all inputs ignored except rst.
  - eject is never asserted.
  - card_in low does NOT leave LOCKED (card retained); only rst clears.
- card_in low in COLLECT/CHECK/GRANTED: go IDLE, clear entry; no eject pulse.
- Simultaneous events:
  - time_out with digit_valid: time_out wins; digit dropped.
  - enter with digit_valid: enter wins; digit not added.
- tries_left saturates at 0, never wraps. digits_cnt saturates at PIN_DIGITS.
- Reset mid-session returns to IDLE. A card still present does not restart a session until card_in is seen low then high.

Decomposition:
- Shared package atm_pkg:
  - state enum for this block.
  - BCD_MAX=9 constant.
  - pin width localparam, PIN_DIGITS*DIGIT_W.
- One natural sub-module, pin_shift_reg: digit shift buffer with count, clear and saturation. The FSM and compare stay in the top.
- The timer instance is connected at the ATM top level, not inside this block.

Test Plan:
- Stored PIN 1234, card inserted, digits 1,2,3,4, enter -> pin_ok pulse 1 cycle after enter; tries_left=3; state GRANTED.
- PIN 1234, entries 1111, 2222, 3333 each followed by enter -> pin_fail pulses with tries_left 2 then 1. Third enter gives card_locked=1, tries_left=0, no pin_fail, no eject. card_in low keeps lock; rst clears it.
- Digits 1,2 then enter -> short entry counts as failure, pin_fail, tries_left=2, digits_cnt=0. Then digits 1,2,3,4, enter -> pin_ok.
- Digits 1, 0xA, 2, 3, 4, 5, enter -> 0xA and 5 ignored; timer_restart pulses exactly 5 times (insertion plus 4 accepted digits); pin_ok.
- In COLLECT, time_out and digit_valid in the same cycle -> eject pulse, IDLE, digits_cnt=0; digit not latched.
- rst asserted during CHECK cycle -> all outputs return to reset values asynchronously. No pin_ok or pin_fail emitted after release.
